pht_update_engine: RTL and testbench
====================================

Name: pht_update_engine

Overview:
- Write-side controller for the 2-bit pattern history table (PHT) storage array.
- Accepts resolved-branch events from execute through a valid/ready handshake and buffers them in a small FIFO.
- Computes a gshare index from the PC and the committed global history register (GHR).
- Reads the current counter, applies a saturating update and writes it back through a 2-stage read-modify-write pipeline with internal hazard forwarding.

Parameters:
- S_INDEX, 10, PHT index width; the table has 2**S_INDEX entries.
- WIDTH, 2, counter width.
- HIST, 8, GHR length; must satisfy HIST <= S_INDEX.
- QDEPTH, 4, resolve FIFO depth; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- resolve_valid  in  1  a resolved branch is offered
- resolve_ready  out  1  FIFO can accept; equals !full
- resolve_pc  in  32  PC of the resolved branch
- resolve_taken  in  1  actual branch outcome
- pa_rindex  out  S_INDEX  PHT read index (combinational, stage A)
- pa_dataout  in  WIDTH  PHT read data (combinational response to pa_rindex)
- pa_load  out  1  PHT write enable (stage B)
- pa_windex  out  S_INDEX  PHT write index
- pa_datain  out  WIDTH  PHT write data
- ghr_out  out  HIST  committed GHR, used by the fetch-side predictor
- upd_count  out  16  number of PHT writes issued, wraps modulo 2**16

Behaviour:
- Reset state: FIFO empty, stage B invalid, ghr = 0, upd_count = 0. Outputs after the reset edge: resolve_ready = 1, pa_load = 0, pa_windex = 0, pa_datain = 0, ghr_out = 0.
- Reset mid-operation:
  - All queued and in-flight updates are discarded; no pa_load in the cycle after the reset edge.
  - A push offered in the reset cycle is dropped.
- FIFO:
  - Push when resolve_valid && resolve_ready.
  - resolve_ready = !full. It does not look ahead to a same-cycle pop, so a full FIFO never accepts, even while popping.
  - Pointers wrap modulo QDEPTH. Occupancy is tracked with a count or an extra pointer bit so that full and empty are distinguishable.
- Stage A (pop):
  - Pops whenever the FIFO is non-empty, one entry per cycle; stage B never stalls.
  - idx = resolve_pc[S_INDEX+1:2] XOR zero-extend(ghr), using the ghr value before this cycle's shift.
  - pa_rindex = idx. When the FIFO is empty, pa_rindex = head entry's computed index (don't-care); never write from an empty pop.
  - On pop: ghr <= {ghr[HIST-2:0], taken}.
  - Forwarded counter: if stage B is valid and B.idx == idx, the current counter is B's new value (pa_datain), otherwise pa_dataout. The array is not relied on for bypass.
- Stage B (registered from A):
  - Holds idx, taken and the current counter.
  - Next value: taken && cnt != all-ones -> cnt+1; !taken && cnt != 0 -> cnt-1; else cnt.
  - pa_load = B.valid, asserted even when the value is unchanged. pa_windex = B.idx, pa_datain = next value.
  - upd_count increments on every cycle pa_load = 1.
- Latency: a push accepted in cycle t into an empty FIFO is popped (stage A) in t+1 and written with pa_load = 1 in t+2. The array holds the new value from edge t+3. ghr_out reflects the branch from edge t+2.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- Back-to-back updates to the same index must compose: two consecutive taken updates on counter 01 yield 10 then 11, never 10 twice.

Test Plan:
- Reset then idle -> resolve_ready = 1, pa_load = 0, ghr_out = 0, upd_count = 0 for 10 cycles.
- Single push with pc = 0x0000_0010, taken = 1, ghr = 0, array entry 4 = 01 -> cycle t+1: pa_rindex = 4. Cycle t+2: pa_load = 1, pa_windex = 4, pa_datain = 10. Then ghr_out = 0x01 and upd_count = 1.
- Three back-to-back pushes with identical index (pc chosen to cancel the changing ghr), all taken, entry = 01 -> writes 10, 11, 11; saturation holds at 11. Same sequence not-taken from 01 -> 00, 00, 00.
- Hold resolve_valid = 1 for 8 cycles while forcing FIFO fill via a reset-free burst -> resolve_ready drops only when 4 entries are queued. No entry is lost or duplicated; upd_count ends at 8.
- GHR pattern: taken sequence 1,0,1,1 from ghr = 0 -> ghr_out = 0x0B. The fourth update's index = pc[11:2] XOR 0x005.
- Assert rst with 3 entries queued and stage B valid -> next cycle pa_load = 0 and resolve_ready = 1. ghr_out = 0, upd_count = 0, and no subsequent writes occur.

Source files
------------

// File: rtl/pht_update_engine.sv
// Write-side controller for the 2-bit pattern history table: buffers resolved
// branches, forms the gshare index and performs a forwarded read-modify-write.
module pht_update_engine #(
  parameter int S_INDEX = 10,
  parameter int WIDTH   = 2,
  parameter int HIST    = 8,
  parameter int QDEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               resolve_valid,
  output logic               resolve_ready,
  input  logic [31:0]        resolve_pc,
  input  logic               resolve_taken,
  output logic [S_INDEX-1:0] pa_rindex,
  input  logic [WIDTH-1:0]   pa_dataout,
  output logic               pa_load,
  output logic [S_INDEX-1:0] pa_windex,
  output logic [WIDTH-1:0]   pa_datain,
  output logic [HIST-1:0]    ghr_out,
  output logic [15:0]        upd_count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  function automatic logic [WIDTH-1:0] sat_next(input logic [WIDTH-1:0] cnt,
                                                input logic taken);
    logic [WIDTH-1:0] res;
    if (taken && (cnt != {WIDTH{1'b1}})) begin
      res = cnt + WIDTH'(1);
    end else if (!taken && (cnt != {WIDTH{1'b0}})) begin
      res = cnt - WIDTH'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Only the index-forming PC bits are queued; the rest are intentionally ignored.
  logic unused_pc_s;
  assign unused_pc_s = ^{resolve_pc[31:S_INDEX+2], resolve_pc[1:0]};

  logic [S_INDEX-1:0] fifo_pc_r [QDEPTH];
  logic [QDEPTH-1:0]  fifo_taken_r;
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [PW:0]        count_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;

  logic [HIST-1:0]    ghr_r;
  logic [S_INDEX-1:0] idx_s;
  logic               head_taken_s;
  logic [WIDTH-1:0]   fwd_cnt_s;

  logic               b_valid_r;
  logic [S_INDEX-1:0] b_idx_r;
  logic               b_taken_r;
  logic [WIDTH-1:0]   b_cnt_r;
  logic [WIDTH-1:0]   next_cnt_s;
  logic [15:0]        upd_count_r;

  assign full_s  = (count_r == (PW+1)'(QDEPTH));
  assign empty_s = (count_r == {(PW+1){1'b0}});
  assign push_s  = resolve_valid && !full_s;
  assign pop_s   = !empty_s;

  assign head_taken_s = fifo_taken_r[rd_ptr_r];
  assign idx_s        = fifo_pc_r[rd_ptr_r] ^ S_INDEX'(ghr_r);
  assign next_cnt_s   = sat_next(b_cnt_r, b_taken_r);

  // Queue storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      fifo_pc_r[wr_ptr_r]    <= resolve_pc[S_INDEX+1:2];
      fifo_taken_r[wr_ptr_r] <= resolve_taken;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Bypass stage B's pending write so back-to-back updates to one entry compose.
  always_comb begin
    fwd_cnt_s = pa_dataout;
    if (b_valid_r && (b_idx_r == idx_s)) begin
      fwd_cnt_s = next_cnt_s;
    end else begin
      fwd_cnt_s = pa_dataout;
    end
  end

  // Stage B register and global history.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_r <= 1'b0;
      b_idx_r   <= {S_INDEX{1'b0}};
      b_taken_r <= 1'b0;
      b_cnt_r   <= {WIDTH{1'b0}};
      ghr_r     <= {HIST{1'b0}};
    end else begin
      b_valid_r <= pop_s;
      if (pop_s) begin
        b_idx_r   <= idx_s;
        b_taken_r <= head_taken_s;
        b_cnt_r   <= fwd_cnt_s;
        ghr_r     <= HIST'({ghr_r, head_taken_s});
      end
    end
  end

  // Count of issued table writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_count_r <= 16'd0;
    end else if (b_valid_r) begin
      upd_count_r <= upd_count_r + 16'd1;
    end
  end

  assign resolve_ready = !full_s;
  assign pa_rindex     = idx_s;
  assign pa_load       = b_valid_r;
  assign pa_windex     = b_idx_r;
  assign pa_datain     = next_cnt_s;
  assign ghr_out       = ghr_r;
  assign upd_count     = upd_count_r;

endmodule

// File: tb/tb_pht_update_engine.sv
// Directed bench for pht_update_engine with a behavioural PHT array attached.
module tb_pht_update_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        resolve_valid = 1'b0;
  logic        resolve_ready;
  logic [31:0] resolve_pc = 32'd0;
  logic        resolve_taken = 1'b0;
  logic [9:0]  pa_rindex;
  logic [1:0]  pa_dataout;
  logic        pa_load;
  logic [9:0]  pa_windex;
  logic [1:0]  pa_datain;
  logic [7:0]  ghr_out;
  logic [15:0] upd_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pht_update_engine #(.S_INDEX(10), .WIDTH(2), .HIST(8), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
    .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .pa_rindex(pa_rindex), .pa_dataout(pa_dataout),
    .pa_load(pa_load), .pa_windex(pa_windex), .pa_datain(pa_datain),
    .ghr_out(ghr_out), .upd_count(upd_count)
  );

  // Behavioural table plus write monitor.
  logic [1:0]  pht [1024];
  logic        set_en = 1'b0;
  logic        clr_all = 1'b0;
  logic [9:0]  set_idx = 10'd0;
  logic [1:0]  set_val = 2'd0;
  logic [11:0] wq[$];

  assign pa_dataout = pht[pa_rindex];

  always @(posedge clk) begin
    if (pa_load) begin
      pht[pa_windex] <= pa_datain;
      wq.push_back({pa_windex, pa_datain});
    end
    if (clr_all) begin
      for (int i = 0; i < 1024; i++) pht[i] <= 2'd0;
    end
    if (set_en) pht[set_idx] <= set_val;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, required summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    resolve_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_pht(input logic [9:0] idx, input logic [1:0] val);
    set_idx = idx;
    set_val = val;
    set_en = 1'b1;
    tick();
    set_en = 1'b0;
  endtask

  task automatic clear_pht();
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
  endtask

  logic [31:0] bpc [8];
  logic        btk [8];
  logic [9:0]  ewi [8];
  logic [1:0]  ewd [8];

  // Push bpc/btk[0..n-1] on consecutive cycles, then let the pipe drain.
  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) begin
      check("ready_during_burst", {31'd0, resolve_ready}, 32'd1);
      resolve_valid = 1'b1;
      resolve_pc = bpc[i];
      resolve_taken = btk[i];
      tick();
    end
    resolve_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic check_writes(input int n);
    check("write_count", wq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wq.size()) begin
        check("write_index", {22'd0, wq[i][11:2]}, {22'd0, ewi[i]});
        check("write_data", {30'd0, wq[i][1:0]}, {30'd0, ewd[i]});
      end
    end
  endtask

  task automatic run3(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                      input logic tk, input logic [1:0] init,
                      input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2);
    do_reset();
    set_pht(10'd4, init);
    wq.delete();
    bpc[0] = p0; bpc[1] = p1; bpc[2] = p2;
    for (int i = 0; i < 3; i++) begin
      btk[i] = tk;
      ewi[i] = 10'd4;
    end
    ewd[0] = d0; ewd[1] = d1; ewd[2] = d2;
    push_seq(3);
    check_writes(3);
    check("upd_count_after3", {16'd0, upd_count}, 32'd3);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [1:0]  init;
    logic [9:0]  idx;
    logic [1:0]  data;
    logic [7:0]  ghr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] rghr;
    logic [1:0] rpht [1024];
    logic [9:0] ridx;
    logic [1:0] rc;

    vecs[0] = '{pc: 32'h0000_0010, taken: 1'b1, init: 2'b01, idx: 10'h004, data: 2'b10, ghr: 8'h01};
    vecs[1] = '{pc: 32'h0000_0010, taken: 1'b0, init: 2'b01, idx: 10'h004, data: 2'b00, ghr: 8'h00};
    vecs[2] = '{pc: 32'h0000_0FFC, taken: 1'b1, init: 2'b11, idx: 10'h3FF, data: 2'b11, ghr: 8'h01};
    vecs[3] = '{pc: 32'h0000_1000, taken: 1'b0, init: 2'b00, idx: 10'h000, data: 2'b00, ghr: 8'h00};
    vecs[4] = '{pc: 32'hFFFF_F2A8, taken: 1'b1, init: 2'b10, idx: 10'h0AA, data: 2'b11, ghr: 8'h01};

    tick();
    do_reset();
    clear_pht();
    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      check("idle_ready", {31'd0, resolve_ready}, 32'd1);
      check("idle_load", {31'd0, pa_load}, 32'd0);
      check("idle_ghr", {24'd0, ghr_out}, 32'd0);
      check("idle_upd_count", {16'd0, upd_count}, 32'd0);
      tick();
    end

    // Single-update latency vectors.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      set_pht(vecs[v].idx, vecs[v].init);
      check("rst_windex", {22'd0, pa_windex}, 32'd0);
      check("rst_datain", {30'd0, pa_datain}, 32'd0);
      resolve_valid = 1'b1;
      resolve_pc = vecs[v].pc;
      resolve_taken = vecs[v].taken;
      tick();
      resolve_valid = 1'b0;
      check("t1_rindex", {22'd0, pa_rindex}, {22'd0, vecs[v].idx});
      check("t1_load", {31'd0, pa_load}, 32'd0);
      tick();
      check("t2_load", {31'd0, pa_load}, 32'd1);
      check("t2_windex", {22'd0, pa_windex}, {22'd0, vecs[v].idx});
      check("t2_datain", {30'd0, pa_datain}, {30'd0, vecs[v].data});
      check("t2_ghr", {24'd0, ghr_out}, {24'd0, vecs[v].ghr});
      tick();
      check("t3_load", {31'd0, pa_load}, 32'd0);
      check("t3_upd_count", {16'd0, upd_count}, 32'd1);
      check("t3_array", {30'd0, pht[vecs[v].idx]}, {30'd0, vecs[v].data});
    end

    // Same index back-to-back: pcs cancel the moving ghr.
    run3(32'h10, 32'h14, 32'h1C, 1'b1, 2'b01, 2'b10, 2'b11, 2'b11);
    run3(32'h10, 32'h10, 32'h10, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
    run3(32'h10, 32'h10, 32'h10, 1'b0, 2'b11, 2'b10, 2'b01, 2'b00);

    // GHR pattern 1,0,1,1: fourth index = 0x2AF ^ 0x005.
    do_reset();
    clear_pht();
    wq.delete();
    bpc[0] = 32'h40;  btk[0] = 1'b1;
    bpc[1] = 32'h80;  btk[1] = 1'b0;
    bpc[2] = 32'hC0;  btk[2] = 1'b1;
    bpc[3] = 32'hABC; btk[3] = 1'b1;
    push_seq(4);
    check("ghr_pattern", {24'd0, ghr_out}, 32'h0B);
    check("ghr_writes", wq.size(), 4);
    if (wq.size() == 4) check("fourth_index", {22'd0, wq[3][11:2]}, 32'h2AA);

    // Eight-cycle burst with collisions, checked against a sequential reference.
    do_reset();
    clear_pht();
    wq.delete();
    bpc[0] = 32'h010; bpc[1] = 32'h014; bpc[2] = 32'h01C; bpc[3] = 32'h010;
    bpc[4] = 32'h200; bpc[5] = 32'h204; bpc[6] = 32'h3FC; bpc[7] = 32'h010;
    btk[0] = 1'b1; btk[1] = 1'b1; btk[2] = 1'b1; btk[3] = 1'b0;
    btk[4] = 1'b1; btk[5] = 1'b0; btk[6] = 1'b1; btk[7] = 1'b1;
    rghr = 8'd0;
    for (int i = 0; i < 1024; i++) rpht[i] = 2'd0;
    for (int i = 0; i < 8; i++) begin
      ridx = bpc[i][11:2] ^ {2'b00, rghr};
      rc = rpht[ridx];
      if (btk[i] && rc != 2'b11) rc = rc + 2'd1;
      else if (!btk[i] && rc != 2'b00) rc = rc - 2'd1;
      rpht[ridx] = rc;
      ewi[i] = ridx;
      ewd[i] = rc;
      rghr = {rghr[6:0], btk[i]};
    end
    push_seq(8);
    check_writes(8);
    check("burst_upd_count", {16'd0, upd_count}, 32'd8);
    check("burst_ghr", {24'd0, ghr_out}, {24'd0, rghr});

    // Reset while the pipe is busy and a push is offered.
    resolve_valid = 1'b1; resolve_pc = 32'h10; resolve_taken = 1'b1;
    tick();
    resolve_pc = 32'h20;
    tick();
    resolve_pc = 32'h30;
    rst = 1'b1;
    tick();
    check("midrst_load", {31'd0, pa_load}, 32'd0);
    check("midrst_ready", {31'd0, resolve_ready}, 32'd1);
    check("midrst_ghr", {24'd0, ghr_out}, 32'd0);
    check("midrst_upd_count", {16'd0, upd_count}, 32'd0);
    rst = 1'b0;
    resolve_valid = 1'b0;
    wq.delete();
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_writes", wq.size(), 0);
    check("midrst_upd_after", {16'd0, upd_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
